// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC processing element.
//  - taps_of / acc_width_of : derive tap count and lossless accumulator width
//  - TAPS / ACC_WIDTH       : values for the default 32-bit, 3x3, 4-channel build
//  - S_*                    : FSM state encoding
//  - saturate               : classifies a wide signed value against a DW-bit range
package conv_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int K_DEFAULT  = 3;
  localparam int C_DEFAULT  = 4;

  // Widest accumulator the saturation helper can classify.
  localparam int SAT_W = 128;

  function automatic int taps_of(input int k);
    return k * k;
  endfunction

  // Full products are 2*DW; summing TAPS*CHANNELS of them adds clog2 bits.
  function automatic int acc_width_of(input int dw, input int k, input int c);
    return 2 * dw + $clog2(k * k * c);
  endfunction

  localparam int TAPS      = taps_of(K_DEFAULT);
  localparam int ACC_WIDTH = acc_width_of(DW_DEFAULT, K_DEFAULT, C_DEFAULT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  typedef struct packed {
    logic hi;  // value above  2^(dw-1)-1
    logic lo;  // value below -2^(dw-1)
  } clip_t;

  // Returns which rail (if any) v must be clipped to for a dw-bit signed result.
  function automatic clip_t saturate(input logic signed [SAT_W-1:0] v, input int dw);
    logic signed [SAT_W-1:0] lim_hi;
    logic signed [SAT_W-1:0] lim_lo;
    clip_t r;
    lim_hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
    lim_lo = ~lim_hi;
    r.hi = (v > lim_hi);
    r.lo = (v < lim_lo);
    return r;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registered reduction of N signed inputs into one sign-extended sum.
//  i_clk : clock, rising edge
//  i_d   : N packed signed operands of IN_W bits
//  o_sum : registered sum, OUT_W bits (OUT_W > IN_W), 1-cycle latency
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter int N     = 9,
  parameter int IN_W  = 64,
  parameter int OUT_W = 70
) (
  input  logic                     i_clk,
  input  logic [N-1:0][IN_W-1:0]   i_d,
  output logic [OUT_W-1:0]         o_sum
);

  logic [OUT_W-1:0] w_sum;
  logic [OUT_W-1:0] r_sum;

  // Written as a chain; synthesis rebalances it into a tree within the stage.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++)
      w_sum = w_sum + {{(OUT_W-IN_W){i_d[i][IN_W-1]}}, i_d[i]};
  end

  always_ff @(posedge i_clk) r_sum <= w_sum;

  assign o_sum = r_sum;

endmodule

// File: rtl/conv_multichannel_mac.sv
// Convolution processing element: one KxK window per channel, parallel multiply,
// registered adder tree, cross-channel accumulation, saturate + optional ReLU,
// result over a valid/ready handshake.
//  Clk, Rst             : clock / synchronous active-high reset
//  pixel_in, weight_in  : flat TAPS*DW signed windows, tap i at [i*DW +: DW]
//  in_valid / in_ready  : window handshake (ready in IDLE/ACCUM)
//  relu_en              : clamp negative results, captured with channel 0
//  abort                : flush current output pixel
//  out_data/out_sat     : result and clip flag, qualified by out_valid
//  out_valid/out_ready  : result handshake
//  busy                 : not idle
module conv_multichannel_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 4
) (
  input  logic                                      Clk,
  input  logic                                      Rst,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_in,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weight_in,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic                                      relu_en,
  input  logic                                      abort,
  output logic [DATA_WIDTH-1:0]                     out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_sat,
  output logic                                      busy
);

  localparam int NT = taps_of(KERNEL_SIZE);
  localparam int AW = acc_width_of(DATA_WIDTH, KERNEL_SIZE, CHANNELS);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [1:0]                       r_state;
  logic [CW-1:0]                    r_ch_cnt;
  logic [NT-1:0][DATA_WIDTH-1:0]    r_pix;
  logic [NT-1:0][DATA_WIDTH-1:0]    r_wt;
  logic [NT-1:0][PW-1:0]            r_prod;
  logic [AW-1:0]                    w_sum;
  logic [AW-1:0]                    r_acc;
  logic                             r_relu;
  // Stage 0: inputs captured, 1: products, 2: tree sum, 3: accumulator updated.
  logic [3:0]                       r_vld_pipe;
  logic [2:0]                       r_first_pipe;
  logic [3:0]                       r_last_pipe;
  logic [DATA_WIDTH-1:0]            r_out_data;
  logic                             r_out_valid;
  logic                             r_out_sat;

  logic                             w_accept;
  logic                             w_last_ch;
  logic                             w_final;
  logic signed [SAT_W-1:0]          w_wide;
  clip_t                            w_clip;
  logic [DATA_WIDTH-1:0]            w_res;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_ACCUM);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid && in_ready && !abort;
  assign w_last_ch = (r_ch_cnt == CW'(CHANNELS - 1));
  assign w_final   = r_vld_pipe[3] && r_last_pipe[3];

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sat   = r_out_sat;

  // Datapath registers carry no reset; the valid pipe qualifies them.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_pix <= pixel_in;
      r_wt  <= weight_in;
    end
  end

  for (genvar i = 0; i < NT; i++) begin : g_mul
    logic [PW-1:0] w_a, w_b;
    assign w_a = {{DATA_WIDTH{r_pix[i][DATA_WIDTH-1]}}, r_pix[i]};
    assign w_b = {{DATA_WIDTH{r_wt[i][DATA_WIDTH-1]}},  r_wt[i]};
    // Low PW bits of the extended product are the exact signed product.
    always_ff @(posedge Clk) r_prod[i] <= w_a * w_b;
  end

  conv_adder_tree #(.N(NT), .IN_W(PW), .OUT_W(AW)) u_tree (
    .i_clk (Clk),
    .i_d   (r_prod),
    .o_sum (w_sum)
  );

  // Saturate first, then ReLU; out_sat reports clipping even if ReLU zeroes it.
  always_comb begin
    w_wide = {{(SAT_W-AW){r_acc[AW-1]}}, r_acc};
    w_clip = saturate(w_wide, DATA_WIDTH);
    w_res  = r_acc[DATA_WIDTH-1:0];
    if (w_clip.hi)      w_res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (w_clip.lo) w_res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    if (r_relu && w_res[DATA_WIDTH-1]) w_res = '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= S_IDLE;
      r_ch_cnt     <= '0;
      r_vld_pipe   <= '0;
      r_first_pipe <= '0;
      r_last_pipe  <= '0;
      r_acc        <= '0;
      r_relu       <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_sat    <= 1'b0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_ch_cnt    <= '0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_vld_pipe   <= {r_vld_pipe[2:0], w_accept};
      r_first_pipe <= {r_first_pipe[1:0], w_accept && (r_ch_cnt == '0)};
      r_last_pipe  <= {r_last_pipe[2:0], w_accept && w_last_ch};

      if (w_accept) begin
        if (r_ch_cnt == '0) r_relu <= relu_en;
        r_ch_cnt <= w_last_ch ? '0 : r_ch_cnt + CW'(1);
      end

      if (r_vld_pipe[2]) r_acc <= r_first_pipe[2] ? w_sum : r_acc + w_sum;

      if (w_final) begin
        r_out_data  <= w_res;
        r_out_sat   <= w_clip.hi || w_clip.lo;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE, S_ACCUM: if (w_accept) r_state <= w_last_ch ? S_DRAIN : S_ACCUM;
        S_DRAIN:         if (w_final) r_state <= S_OUTPUT;
        default:         if (out_ready) r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_multichannel_mac.sv
module tb_conv_multichannel_mac;
  localparam int DW = 32;
  localparam int K  = 3;
  localparam int C  = 4;
  localparam int T  = K * K;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [T*DW-1:0] pixel_in, weight_in;
  logic            in_valid, in_ready, relu_en, abort;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_ready, out_sat, busy;

  conv_multichannel_mac #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .CHANNELS(C)) dut (
    .Clk(Clk), .Rst(Rst), .pixel_in(pixel_in), .weight_in(weight_in),
    .in_valid(in_valid), .in_ready(in_ready), .relu_en(relu_en), .abort(abort),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sat(out_sat), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Abstract view: count channels taken, keep the exact running dot-product sum,
  // a countdown to the result, and the held result itself.
  int                  m_cnt  = 0;
  int                  m_wait = -1;
  logic signed [127:0] m_acc  = '0;
  logic                m_relu = 1'b0;
  logic                m_ov   = 1'b0;
  logic                m_os   = 1'b0;
  logic [DW-1:0]       m_od   = '0;

  function automatic logic signed [127:0] dot(input logic [T*DW-1:0] p, input logic [T*DW-1:0] w);
    logic signed [DW-1:0]  a, b;
    logic signed [127:0]   aw, bw, s;
    s = '0;
    for (int i = 0; i < T; i++) begin
      a = p[i*DW +: DW];
      b = w[i*DW +: DW];
      aw = a;
      bw = b;
      s = s + aw * bw;
    end
    return s;
  endfunction

  always @(posedge Clk) begin
    logic                rdy;
    logic signed [127:0] hi, lo;
    rdy = !m_ov && (m_wait < 0);
    hi  = 128'sd2147483647;
    lo  = -128'sd2147483648;
    if (Rst) begin
      m_cnt = 0; m_wait = -1; m_acc = '0; m_relu = 0; m_ov = 0; m_os = 0; m_od = '0;
    end else if (abort) begin
      m_cnt = 0; m_wait = -1; m_ov = 0;
    end else begin
      if (m_ov && out_ready) m_ov = 0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          if (m_acc > hi)      begin m_od = 32'h7FFF_FFFF; m_os = 1; end
          else if (m_acc < lo) begin m_od = 32'h8000_0000; m_os = 1; end
          else                 begin m_od = m_acc[DW-1:0]; m_os = 0; end
          if (m_relu && m_od[DW-1]) m_od = '0;
          m_ov = 1;
          m_wait = -1;
        end
      end
      if (in_valid && rdy) begin
        if (m_cnt == 0) begin m_relu = relu_en; m_acc = dot(pixel_in, weight_in); end
        else m_acc = m_acc + dot(pixel_in, weight_in);
        m_cnt++;
        if (m_cnt == C) begin m_cnt = 0; m_wait = 4; end
      end
    end
    #1;
    chk("in_ready",  in_ready,  !m_ov && (m_wait < 0));
    chk("out_valid", out_valid, m_ov);
    chk("busy",      busy,      m_ov || (m_wait >= 0) || (m_cnt > 0));
    chk("out_data",  out_data,  m_od);
    chk("out_sat",   out_sat,   m_os);
  end

  // ---------------- directed helpers ----------------
  task automatic send_pixel(input logic [DW-1:0] pv, input logic [DW-1:0] wv, input logic relu,
                            input int gap, input bit wait_out, output int lat);
    lat = -1;
    for (int c = 0; c < C; c++) begin
      @(negedge Clk);
      pixel_in = {T{pv}}; weight_in = {T{wv}}; in_valid = 1'b1; relu_en = relu;
      @(posedge Clk);
      if (gap > 0 && c < C - 1) begin
        @(negedge Clk); in_valid = 1'b0;
        repeat (gap - 1) @(negedge Clk);
      end
    end
    @(negedge Clk); in_valid = 1'b0;
    if (wait_out)
      for (int k = 1; k <= 20; k++) begin
        @(posedge Clk); #1;
        if (out_valid) begin lat = k; break; end
      end
  endtask

  task automatic take();
    @(negedge Clk); out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk); out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    Rst = 1'b1; pixel_in = '0; weight_in = '0; in_valid = 0; relu_en = 0; abort = 0; out_ready = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    @(negedge Clk); Rst = 1'b0;

    // 1: ones x twos, back-to-back
    send_pixel(32'd1, 32'd2, 1'b0, 0, 1'b1, lat);
    chk("t1_latency", lat, 4);
    chk("t1_data", out_data, 32'd72);
    chk("t1_sat", out_sat, 1'b0);
    chk("t1_model", m_od, 32'd72);
    take();

    // 6b: gaps inside ACCUM give the same result
    send_pixel(32'd1, 32'd2, 1'b0, 2, 1'b1, lat);
    chk("gap_data", out_data, 32'd72);
    take();

    // 2: negative result with and without ReLU
    send_pixel(32'hFFFF_FFFF, 32'd1, 1'b1, 0, 1'b1, lat);
    chk("relu_data", out_data, 32'd0);
    chk("relu_sat", out_sat, 1'b0);
    take();
    send_pixel(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b1, lat);
    chk("neg_data", out_data, 32'hFFFF_FFDC);
    chk("neg_model", m_od, 32'hFFFF_FFDC);
    take();

    // 3: saturation both rails
    send_pixel(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 0, 1'b1, lat);
    chk("sat_hi_data", out_data, 32'h7FFF_FFFF);
    chk("sat_hi_flag", out_sat, 1'b1);
    take();
    send_pixel(32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 0, 1'b1, lat);
    chk("sat_lo_data", out_data, 32'h8000_0000);
    chk("sat_lo_flag", out_sat, 1'b1);
    chk("sat_lo_model", m_os, 1'b1);
    take();

    // 4: backpressure holds the result
    send_pixel(32'd1, 32'd1, 1'b0, 0, 1'b1, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, 32'd36);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    @(negedge Clk); out_ready = 1'b1;
    @(posedge Clk); #1;
    chk("release_valid", out_valid, 1'b0);
    chk("release_idle", busy, 1'b0);
    @(negedge Clk); out_ready = 1'b0;
    send_pixel(32'd1, 32'd3, 1'b0, 0, 1'b1, lat);
    chk("after_hold_data", out_data, 32'd108);
    take();

    // 5: abort after two channels, discarded same-cycle window
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk); pixel_in = {T{32'd5}}; weight_in = {T{32'd5}}; in_valid = 1'b1;
      @(posedge Clk);
    end
    @(negedge Clk); abort = 1'b1;
    @(posedge Clk); #1;
    chk("abort_busy", busy, 1'b0);
    @(negedge Clk); abort = 1'b0; in_valid = 1'b0;
    send_pixel(32'd1, 32'd1, 1'b0, 0, 1'b1, lat);
    chk("abort_next_data", out_data, 32'd36);
    chk("abort_next_lat", lat, 4);
    take();

    // 6a: reset in DRAIN, then in OUTPUT
    send_pixel(32'd2, 32'd2, 1'b0, 0, 1'b0, lat);
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk("rst_drain_busy", busy, 1'b0);
    chk("rst_drain_data", out_data, 32'd0);
    chk("rst_drain_ready", in_ready, 1'b1);
    @(negedge Clk); Rst = 1'b0;
    repeat (6) @(posedge Clk);
    #1 chk("rst_drain_no_out", out_valid, 1'b0);
    send_pixel(32'd1, 32'd1, 1'b0, 0, 1'b1, lat);
    chk("pre_rst_out", out_data, 32'd36);
    @(negedge Clk); Rst = 1'b1;
    @(posedge Clk); #1;
    chk("rst_out_valid2", out_valid, 1'b0);
    chk("rst_out_data2", out_data, 32'd0);
    chk("rst_out_sat2", out_sat, 1'b0);
    @(negedge Clk); Rst = 1'b0;

    // randomized phase; the per-cycle compare process checks everything
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int mode;
      @(negedge Clk);
      mode = $urandom_range(0, 3);
      for (int i = 0; i < T; i++) begin
        if (mode == 0) begin
          pixel_in[i*DW +: DW]  = $urandom;
          weight_in[i*DW +: DW] = $urandom;
        end else begin
          pixel_in[i*DW +: DW]  = DW'($signed($urandom_range(0, 200)) - 100);
          weight_in[i*DW +: DW] = DW'($signed($urandom_range(0, 200)) - 100);
        end
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      relu_en   = $urandom_range(0, 1);
      abort     = ($urandom_range(0, 99) < 2);
      out_ready = ($urandom_range(0, 9) < 6);
      Rst       = ($urandom_range(0, 499) == 0);
    end
    @(negedge Clk);
    in_valid = 0; abort = 0; Rst = 0; out_ready = 1;
    repeat (8) @(posedge Clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
